// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that fills instruction memory and gates CPU reset
//
// Parses a length byte followed by big-endian 32-bit words from a byte stream and
// writes one instruction-memory word per instruction. The CPU is held in reset
// until a complete, valid program has been written.
//
// Ports:
//   clk, reset            system clock; asynchronous active-high reset
//   start                 single-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_valid, in_data     byte stream input
//   in_ready              loader accepts a byte (transfer = in_valid & in_ready)
//   mem_we                one-cycle word write strobe
//   mem_addr, mem_wdata   byte address (index << 2) and word; held between writes
//   cpu_hold              1 = CPU held in reset (0 only in DONE)
//   busy, done, error     load in progress / program loaded / bad length byte
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] idx;
  logic [1:0]       byte_cnt;
  logic [CNT_W-1:0] count;
  logic [31:0]      word;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;

  logic fire;
  logic len_bad;
  logic last_word;

  assign fire      = in_valid & in_ready;
  assign len_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_B);
  assign last_word = ({1'b0, idx} + 1'b1) == count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (fire) state_nx = len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (fire && byte_cnt == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        busy     = 1'b1;
        state_nx = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nx = S_LEN;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_nx = S_LEN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Write address/data are latched on the 4th-byte edge so they are valid during
  // WRITE and then hold until the next word completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      byte_cnt <= '0;
      count    <= '0;
      word     <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
    end else begin
      case (state)
        S_LEN: begin
          if (fire && !len_bad) begin
            count    <= in_data[CNT_W-1:0];
            idx      <= '0;
            byte_cnt <= '0;
          end
        end
        S_DATA: begin
          if (fire) begin
            word     <= {word[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wdata_r <= {word[23:0], in_data};
              addr_r  <= {{(32-IDX_W-2){1'b0}}, idx, 2'b00};
            end
          end
        end
        S_WRITE: begin
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prog [0:31];
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  bit          start_noise = 0;

  imem_loader #(.DEPTH(32), .IDX_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Record every write; the loader must never offer a byte slot during a write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_q.push_back({mem_addr, mem_wdata});
      check("ready_in_write", {31'b0, in_ready}, 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_mem_we"},   {31'b0, mem_we},   32'd0);
    check({tag, "_addr"},     mem_addr,          32'd0);
    check({tag, "_wdata"},    mem_wdata,         32'd0);
    check({tag, "_hold"},     {31'b0, cpu_hold}, 32'd1);
    check({tag, "_busy"},     {31'b0, busy},     32'd0);
    check({tag, "_done"},     {31'b0, done},     32'd0);
    check({tag, "_error"},    {31'b0, error},    32'd0);
  endtask

  // Called and returns at a negedge; the byte transfers on the posedge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    while (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("handshake_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_addr"},  obs_q[i][63:32], exp_q[i][63:32]);
      check({tag, "_wdata"}, obs_q[i][31:0],  exp_q[i][31:0]);
    end
  endtask

  // Full load from IDLE/DONE/ERROR using prog[]; len_b is the raw length byte.
  task automatic run_load(input string tag, input int len_b, input bit gaps);
    bit bad;
    bad = (len_b == 0) || (len_b > 32);
    exp_q.delete();
    if (!bad)
      for (int i = 0; i < len_b; i++) exp_q.push_back({32'(i * 4), prog[i]});
    pulse_start();
    check({tag, "_busy_len"}, {31'b0, busy}, 32'd1);
    check({tag, "_hold_len"}, {31'b0, cpu_hold}, 32'd1);
    check({tag, "_done_len"}, {31'b0, done}, 32'd0);
    obs_q.delete();
    send_byte(8'(len_b), gaps);
    if (bad) begin
      check({tag, "_error"}, {31'b0, error}, 32'd1);
      check({tag, "_hold_err"}, {31'b0, cpu_hold}, 32'd1);
      repeat (3) @(negedge clk);
    end else begin
      start_noise = 1;
      for (int w = 0; w < len_b; w++) begin
        for (int b = 0; b < 4; b++) send_byte(prog[w][31-8*b -: 8], gaps);
        check({tag, "_we_lat"}, {31'b0, mem_we}, 32'd1);
      end
      start_noise = 0;
      @(negedge clk);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_hold_done"}, {31'b0, cpu_hold}, 32'd0);
      check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    end
    compare_writes(tag);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed program, valid held high, then the same program with random gaps.
    prog[0] = 32'h20080014;
    prog[1] = 32'h2009000F;
    prog[2] = 32'h0128802A;
    run_load("dir", 3, 0);
    run_load("gap", 3, 1);

    // Length boundaries.
    run_load("len0", 0, 0);
    run_load("len33", 33, 1);
    for (int i = 0; i < 32; i++) prog[i] = $urandom;
    run_load("len32", 32, 0);
    if (obs_q.size() == 32) check("len32_last_addr", obs_q[31][63:32], 32'h7C);

    // Reload from DONE with a single zero word.
    prog[0] = 32'h0;
    run_load("reload", 1, 1);

    // Randomized loads.
    for (int it = 0; it < 10; it++) begin
      int l;
      l = (it % 4 == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 32));
      for (int i = 0; i < 32; i++) prog[i] = $urandom;
      run_load($sformatf("rnd%0d", it), l, 1);
    end

    // Reset mid-load: word 0 written, 2 bytes of word 1 delivered, then async reset.
    prog[0] = 32'hDEADBEEF;
    prog[1] = 32'h01234567;
    pulse_start();
    obs_q.delete();
    send_byte(8'd2, 0);
    for (int b = 0; b < 4; b++) send_byte(prog[0][31-8*b -: 8], 0);
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("areset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h45;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    compare_writes("areset");
    check("areset_hold", {31'b0, cpu_hold}, 32'd1);
    check("areset_done", {31'b0, done}, 32'd0);
    check("areset_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot/reload controller that fills the instruction memory from a byte-wide stream before the mono-cycle CPU runs. It parses a length byte and then big-endian instruction words, and issues one word write per instruction to the instruction memory's write port. It holds the CPU in reset (cpu_hold) until a complete, valid program has been written. It sits between the external program source (UART/testbench) and the instruction memory.

Parameters:
DEPTH, 32, number of 32-bit words in instruction memory; legal length byte range is 1..DEPTH
IDX_W, 5, width of the internal word index counter (clog2 DEPTH)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte; transfer when in_valid & in_ready on clk edge
mem_we  output  1  instruction memory word write enable, one-cycle pulse per word
mem_addr  output  32  byte address of write = word index << 2 (matches fetch addressing)
mem_wdata  output  32  instruction word to write
cpu_hold  output  1  1 = CPU held in reset; 0 only in DONE
busy  output  1  1 in LEN, DATA, WRITE
done  output  1  1 in DONE
error  output  1  1 in ERROR (bad length byte)

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, byte_cnt=0, count=0, shift word=0; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0. Partially assembled words are discarded; memory contents are not cleared.
- All outputs are functions of registered state and registers only; in_ready is never combinationally dependent on in_valid.
- IDLE: in_ready=0. start=1 -> LEN.
- LEN: in_ready=1, busy=1. On transfer: byte==0 or byte>DEPTH -> ERROR; otherwise count=byte, idx=0, byte_cnt=0 -> DATA.
- DATA: in_ready=1, busy=1. On transfer: word = {word[23:0], in_data} (first byte lands in bits 31:24), byte_cnt++. On transfer of 4th byte (byte_cnt==3) -> WRITE; byte_cnt returns to 0.
- WRITE: exactly one cycle; in_ready=0, mem_we=1, mem_addr=idx<<2, mem_wdata=assembled word. Next: idx++; if idx+1==count -> DONE else DATA.
- DONE: done=1, cpu_hold=0, busy=0, in_ready=0. start=1 -> LEN; done=0 and cpu_hold=1 from the next cycle.
- ERROR: error=1, cpu_hold=1, in_ready=0. start=1 -> LEN; error clears.
- start is ignored in LEN, DATA and WRITE.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- in_valid gaps stall the FSM indefinitely without timeout. Bytes are consumed only on transfer cycles.
- Minimum throughput: 5 cycles per word (4 transfers + 1 WRITE). Latency from the 4th byte transfer edge to mem_we high is 1 cycle.
- Idx wrap cannot occur: count<=DEPTH. The last write address is (count-1)<<2.

Test Plan:
1. Assert reset mid-cycle with no clk edge -> all outputs at reset values immediately; cpu_hold=1, mem_we=0.
2. start, then bytes 03, 20 08 00 14, 20 09 00 0F, 01 28 80 2A with in_valid held high -> mem_we pulses at addr 0x0/0x4/0x8 with wdata 0x20080014/0x2009000F/0x0128802A; done=1, cpu_hold=0 one cycle after the last WRITE.
3. Same program with in_valid toggling randomly -> identical write sequence; no byte lost or duplicated; in_ready=0 in each WRITE cycle while the next byte is held.
4. Length byte 00 -> error=1, no mem_we. Length 33 -> error=1. Length 32 with 128 data bytes -> 32 writes, last mem_addr=0x7C, done=1.
5. Reset asserted after 2 data bytes of word 1 (word 0 already written) -> state IDLE, no further mem_we, cpu_hold=1, done=0.
6. From DONE, pulse start and load 01, 00 00 00 00 -> done drops and cpu_hold=1 the next cycle; single write addr 0x0 data 0x00000000; done returns to 1. Pulses of start during DATA have no effect.
